// File: rtl/pipeline_control_pkg.sv
// Shared decode tables for pipeline_control: opcodes, funct codes, ALU-op codes,
// control-bundle field positions and the control FSM state type.
package pipeline_control_pkg;

    localparam int OP_W  = 6;
    localparam int REG_W = 5;
    localparam int ALU_W = 3;
    localparam int CNT_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_MUL = 6'b011000;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_MUL = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;

    // EX bundle = {ALUop, ALUsrc, RegDst}
    localparam int EX_REGDST_BIT = 0;
    localparam int EX_ALUSRC_BIT = 1;
    localparam int EX_ALUOP_LSB  = 2;

    // MEM bundle = {MEM_cs, MEM_we}; WB bundle = {WB_mux, Reg_we}
    localparam logic [1:0] MEM_NONE   = 2'b00;
    localparam logic [1:0] MEM_LOAD   = 2'b10;
    localparam logic [1:0] MEM_STORE  = 2'b11;
    localparam logic [1:0] WB_ALU_REG = 2'b11;
    localparam logic [1:0] WB_MEM_REG = 2'b01;
    localparam logic [1:0] WB_STORE   = 2'b10;

    // PC_ctrl = {taken, jump/branch-select}
    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MUL_BUSY = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_decode.sv
// Combinational ID-stage decode: op/func/is_equal -> EX/MEM/WB bundles, PC select, illegal.
// Macro PIPE_CTRL_BNE_EN enables BNE as a branch; otherwise BNE decodes as illegal.
module pipeline_decode
    import pipeline_control_pkg::*;
#(
    parameter int ALUOP_W = 3
) (
    input  logic [OP_W-1:0]    op_i,
    input  logic [OP_W-1:0]    func_i,
    input  logic               is_equal_i,
    output logic [ALUOP_W+1:0] ex_o,
    output logic [1:0]         mem_o,
    output logic [1:0]         wb_o,
    output logic [1:0]         pc_o,
    output logic               is_mul_o,
    output logic               illegal_o
);

    logic [ALU_W-1:0] alu_op;
    logic             alu_src;
    logic             reg_dst;
    logic             writes;

    always_comb begin
        alu_op    = '0;
        alu_src   = 1'b0;
        reg_dst   = 1'b0;
        writes    = 1'b0;
        mem_o     = MEM_NONE;
        wb_o      = '0;
        pc_o      = PC_SEQ;
        is_mul_o  = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                writes = 1'b1;
                case (func_i)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_MUL: begin
                        alu_op   = ALU_MUL;
                        is_mul_o = 1'b1;
                    end
                    default: begin
                        writes    = 1'b0;
                        illegal_o = 1'b1;
                    end
                endcase
                if (writes) begin
                    reg_dst = 1'b1;
                    wb_o    = WB_ALU_REG;
                end
            end
            OP_ADDI: begin
                alu_op  = ALU_ADD;
                alu_src = 1'b1;
                wb_o    = WB_ALU_REG;
            end
            OP_LW: begin
                alu_op  = ALU_ADD;
                alu_src = 1'b1;
                mem_o   = MEM_LOAD;
                wb_o    = WB_MEM_REG;
            end
            OP_SW: begin
                alu_op  = ALU_ADD;
                alu_src = 1'b1;
                mem_o   = MEM_STORE;
                wb_o    = WB_STORE;
            end
            OP_J:   pc_o = PC_JUMP;
            OP_BEQ: pc_o = is_equal_i ? PC_BRANCH : PC_SEQ;
`ifdef PIPE_CTRL_BNE_EN
            OP_BNE: pc_o = is_equal_i ? PC_SEQ : PC_BRANCH;
`else
            OP_BNE: illegal_o = 1'b1;
`endif
            default: illegal_o = 1'b1;
        endcase
    end

    always_comb begin
        ex_o = '0;
        ex_o[EX_REGDST_BIT] = reg_dst;
        ex_o[EX_ALUSRC_BIT] = alu_src;
        ex_o[ALUOP_W+EX_ALUOP_LSB-1:EX_ALUOP_LSB] = ALUOP_W'(alu_op);
    end

endmodule

// File: rtl/pipeline_control.sv
// ID-stage pipeline controller: ID/EX control bundle registers, load-use and
// multi-cycle MUL interlocks, branch/jump redirect. See pipeline_decode for PIPE_CTRL_BNE_EN.
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int MUL_LAT = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic [OP_W-1:0]    func_i,
    input  logic [REG_W-1:0]   rs_i,
    input  logic [REG_W-1:0]   rt_i,
    input  logic               is_equal_i,
    output logic [1:0]         PC_ctrl_o,
    output logic [ALUOP_W+1:0] EX_ctrl_o,
    output logic [1:0]         MEM_ctrl_o,
    output logic [1:0]         WB_ctrl_o,
    output logic               stall_o,
    output logic               flush_o,
    output logic               illegal_o
);

    logic [ALUOP_W+1:0] dec_ex;
    logic [1:0]         dec_mem, dec_wb, dec_pc;
    logic               dec_mul, dec_illegal;

    pipeline_decode #(.ALUOP_W(ALUOP_W)) u_decode (
        .op_i       (op_i),
        .func_i     (func_i),
        .is_equal_i (is_equal_i),
        .ex_o       (dec_ex),
        .mem_o      (dec_mem),
        .wb_o       (dec_wb),
        .pc_o       (dec_pc),
        .is_mul_o   (dec_mul),
        .illegal_o  (dec_illegal)
    );

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [ALUOP_W+1:0] ex_q, ex_nxt;
    logic [1:0]         mem_q, mem_nxt, wb_q, wb_nxt;
    logic [REG_W-1:0]   ex_rt_q, ex_rt_nxt;
    logic               stall, load_use, issue;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            ex_rt_q <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            ex_q    <= ex_nxt;
            mem_q   <= mem_nxt;
            wb_q    <= wb_nxt;
            ex_rt_q <= ex_rt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        ex_nxt    = ex_q;
        mem_nxt   = mem_q;
        wb_nxt    = wb_q;
        ex_rt_nxt = ex_rt_q;
        stall     = 1'b0;
        load_use  = 1'b0;
        issue     = 1'b0;
        if (state_q == MUL_BUSY) begin
            // EX stays occupied by the MUL: bundle and rt hold, front end stalls
            stall   = 1'b1;
            cnt_nxt = cnt_q - 1'b1;
            if (cnt_nxt == '0)
                state_nxt = RUN;
        end else begin
            load_use = valid_i && (mem_q == MEM_LOAD) && (wb_q == WB_MEM_REG) &&
                       (ex_rt_q != '0) && (ex_rt_q == rs_i || ex_rt_q == rt_i);
            stall     = load_use;
            issue     = valid_i && !load_use && !dec_illegal;
            ex_nxt    = issue ? dec_ex  : '0;
            mem_nxt   = issue ? dec_mem : '0;
            wb_nxt    = issue ? dec_wb  : '0;
            ex_rt_nxt = issue ? rt_i    : '0;
            state_nxt = RUN;
            if (load_use) begin
                state_nxt = LU_STALL;
            end else if (issue && dec_mul && MUL_LAT > 1) begin
                state_nxt = MUL_BUSY;
                cnt_nxt   = CNT_W'(MUL_LAT - 1);
            end
        end
    end

    logic front_ok;
    assign front_ok   = valid_i && !stall && !rst_i;
    assign stall_o    = stall && !rst_i;
    assign PC_ctrl_o  = front_ok ? dec_pc : PC_SEQ;
    assign flush_o    = front_ok && (dec_pc != PC_SEQ);
    assign illegal_o  = front_ok && dec_illegal;
    assign EX_ctrl_o  = ex_q;
    assign MEM_ctrl_o = mem_q;
    assign WB_ctrl_o  = wb_q;

endmodule
